// File: rtl/pipe_mult_sel.sv
// Three-stage multiply / extend / invert datapath with valid/ready handshaking.
// Each item's mode and invert flag travel with its operands so they stay aligned under stalls.
module pipe_mult_sel #(
   parameter int A_W   = 4,
   parameter int B_W   = 2,
   parameter int OUT_W = 8
) (
   input  logic             clk,
   input  logic             res,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [A_W-1:0]   in_a,
   input  logic [B_W-1:0]   in_b,
   input  logic [1:0]       in_mode,
   input  logic             in_inv,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data
);

   generate
      if (OUT_W < A_W + B_W) begin : g_bad_width
         $error("pipe_mult_sel: OUT_W must be at least A_W+B_W");
      end
   endgenerate

   function automatic logic [OUT_W-1:0] compute(input logic [A_W-1:0] a,
                                                input logic [B_W-1:0] b,
                                                input logic [1:0]     mode);
      logic        [A_W+B_W-1:0] prod_u;
      logic signed [A_W+B_W-1:0] prod_s;
      logic signed [A_W-1:0]     a_s;
      prod_u = {{B_W{1'b0}}, a} * {{A_W{1'b0}}, b};
      prod_s = $signed({{B_W{a[A_W-1]}}, a}) * $signed({{A_W{b[B_W-1]}}, b});
      a_s    = $signed(a);
      case (mode)
         2'b00:   compute = OUT_W'(prod_u);
         2'b01:   compute = OUT_W'(prod_s);
         2'b10:   compute = OUT_W'(a_s);
         default: compute = OUT_W'(a);
      endcase
   endfunction

   logic             vld_p1, vld_p2, vld_p3;
   logic             rdy_p1, rdy_p2, rdy_p3;
   logic [A_W-1:0]   a_p1;
   logic [B_W-1:0]   b_p1;
   logic [1:0]       mode_p1;
   logic             inv_p1, inv_p2;
   logic [OUT_W-1:0] r_p2;
   logic [OUT_W-1:0] data_p3;

   assign rdy_p3    = ~vld_p3 | out_ready;
   assign rdy_p2    = ~vld_p2 | rdy_p3;
   assign rdy_p1    = ~vld_p1 | rdy_p2;
   assign in_ready  = rdy_p1;
   assign out_valid = vld_p3;
   assign out_data  = data_p3;

   // Stage 1: operand capture
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         vld_p1  <= 1'b0;
         a_p1    <= '0;
         b_p1    <= '0;
         mode_p1 <= '0;
         inv_p1  <= 1'b0;
      end else if (flush) begin
         vld_p1 <= 1'b0;
      end else if (rdy_p1) begin
         vld_p1 <= in_valid;
         if (in_valid) begin
            a_p1    <= in_a;
            b_p1    <= in_b;
            mode_p1 <= in_mode;
            inv_p1  <= in_inv;
         end
      end
   end

   // Stage 2: mode-selected multiply or extend
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         vld_p2 <= 1'b0;
         r_p2   <= '0;
         inv_p2 <= 1'b0;
      end else if (flush) begin
         vld_p2 <= 1'b0;
      end else if (rdy_p2) begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            r_p2   <= compute(a_p1, b_p1, mode_p1);
            inv_p2 <= inv_p1;
         end
      end
   end

   // Stage 3: optional inversion into the output register
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         vld_p3  <= 1'b0;
         data_p3 <= '0;
      end else if (flush) begin
         vld_p3 <= 1'b0;
      end else if (rdy_p3) begin
         vld_p3 <= vld_p2;
         if (vld_p2) begin
            data_p3 <= inv_p2 ? ~r_p2 : r_p2;
         end
      end
   end

endmodule

// File: tb/tb_pipe_mult_sel.sv
// Bench for pipe_mult_sel: directed vectors, backpressure, streaming, flush, reset,
// and a wider parameter set, checked against an arithmetic reference model.
module tb_pipe_mult_sel;

   logic       clk = 1'b0;
   logic       res;
   logic       flush;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_a;
   logic [1:0] in_b;
   logic [1:0] in_mode;
   logic       in_inv;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;

   logic       flush2;
   logic       in_valid2;
   logic       in_ready2;
   logic [5:0] in_a2;
   logic [2:0] in_b2;
   logic [1:0] in_mode2;
   logic       in_inv2;
   logic       out_valid2;
   logic       out_ready2;
   logic [9:0] out_data2;

   int checks = 0;
   int fails  = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   pipe_mult_sel dut (
      .clk(clk), .res(res), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_inv(in_inv),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
   );

   pipe_mult_sel #(.A_W(6), .B_W(3), .OUT_W(10)) dut2 (
      .clk(clk), .res(res), .flush(flush2),
      .in_valid(in_valid2), .in_ready(in_ready2),
      .in_a(in_a2), .in_b(in_b2), .in_mode(in_mode2), .in_inv(in_inv2),
      .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2)
   );

   // Reference: plain integer arithmetic on the operand values, truncated to 8 bits.
   function automatic logic [7:0] model(input logic [3:0] a, input logic [1:0] b,
                                        input logic [1:0] m, input logic inv);
      int sa, sb, r;
      sa = (a > 4'd7) ? int'(a) - 16 : int'(a);
      sb = (b > 2'd1) ? int'(b) - 4 : int'(b);
      case (m)
         2'd0:    r = int'(a) * int'(b);
         2'd1:    r = sa * sb;
         2'd2:    r = sa;
         default: r = int'(a);
      endcase
      if (inv) r = ~r;
      return r[7:0];
   endfunction

   // One cycle: drive at negedge, then report what will happen at the next posedge.
   task automatic drive_cycle(input logic v, input logic [3:0] a, input logic [1:0] b,
                              input logic [1:0] m, input logic inv, input logic fl,
                              input logic ordy, output logic acc, output logic dlv,
                              output logic [7:0] dout);
      @(negedge clk);
      in_valid = v; in_a = a; in_b = b; in_mode = m; in_inv = inv;
      flush = fl; out_ready = ordy;
      #1;
      acc  = in_valid && in_ready && !flush;
      dlv  = out_valid && out_ready;
      dout = out_data;
      if (acc) exp_q.push_back(model(a, b, m, inv));
   endtask

   task automatic test_reset;
      checks++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++;
      if (out_data !== 8'h00) begin fails++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
      checks++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_directed;
      logic [3:0] a_t  [5] = '{4'h5, 4'hA, 4'hA, 4'hD, 4'h7};
      logic [1:0] b_t  [5] = '{2'h3, 2'h0, 2'h0, 2'h3, 2'h2};
      logic [1:0] m_t  [5] = '{2'd0, 2'd2, 2'd3, 2'd1, 2'd1};
      logic       i_t  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [7:0] e_t  [5] = '{8'hF0, 8'h05, 8'h0A, 8'h03, 8'hF2};
      logic acc, dlv;
      logic [7:0] d;
      int lat;
      for (int n = 0; n < 5; n++) begin
         exp_q.delete();
         drive_cycle(1'b1, a_t[n], b_t[n], m_t[n], i_t[n], 1'b0, 1'b1, acc, dlv, d);
         lat = 0;
         dlv = 1'b0;
         while (!dlv && lat < 10) begin
            drive_cycle(1'b0, 4'h0, 2'h0, 2'd0, 1'b0, 1'b0, 1'b1, acc, dlv, d);
            lat++;
         end
         checks++;
         if (lat !== 3) begin fails++; $display("FAIL directed_latency[%0d]: got %0d expected 3", n, lat); end
         checks++;
         if (d !== e_t[n]) begin fails++; $display("FAIL directed_data[%0d]: got %h expected %h", n, d, e_t[n]); end
      end
      exp_q.delete();
   endtask

   task automatic test_backpressure;
      logic acc, dlv;
      logic [7:0] d, e;
      int acc_n = 0, nxt = 1, k = 1, last_c = 0, gaps = 0;
      exp_q.delete();
      for (int c = 0; c < 5; c++) begin
         drive_cycle(1'b1, 4'(nxt), 2'h0, 2'd3, 1'b0, 1'b0, 1'b0, acc, dlv, d);
         if (acc) begin acc_n++; nxt++; end
         if (c >= 3) begin
            checks++;
            if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", c, in_ready); end
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h01) begin
               fails++; $display("FAIL bp_hold[%0d]: got v=%b d=%h expected v=1 d=01", c, out_valid, out_data);
            end
         end
      end
      checks++;
      if (acc_n !== 3) begin fails++; $display("FAIL bp_accepted: got %0d expected 3", acc_n); end
      for (int c = 0; c < 20 && k <= 5; c++) begin
         drive_cycle(nxt <= 5, 4'(nxt), 2'h0, 2'd3, 1'b0, 1'b0, 1'b1, acc, dlv, d);
         if (acc) nxt++;
         if (dlv) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (d !== 8'(k) || d !== e) begin fails++; $display("FAIL bp_drain[%0d]: got %h expected %h", k, d, 8'(k)); end
            if (k > 1 && last_c != c - 1) gaps++;
            last_c = c;
            k++;
         end
      end
      checks++;
      if (k !== 6 || gaps !== 0) begin fails++; $display("FAIL bp_stream: got %0d results %0d gaps expected 5 results 0 gaps", k - 1, gaps); end
   endtask

   task automatic test_streaming;
      logic acc, dlv;
      logic [7:0] d, e;
      logic [3:0] a;
      logic [1:0] b, m;
      logic inv;
      int sent = 0, got = 0, first_c = -1, last_c = 0;
      exp_q.delete();
      a = 4'($urandom); b = 2'($urandom); m = 2'($urandom); inv = 1'($urandom);
      for (int c = 0; c < 60 && !(sent == 16 && exp_q.size() == 0); c++) begin
         drive_cycle(sent < 16, a, b, m, inv, 1'b0, 1'b1, acc, dlv, d);
         if (acc) begin
            sent++;
            a = 4'($urandom); b = 2'($urandom); m = 2'($urandom); inv = 1'($urandom);
         end
         if (dlv) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (d !== e) begin fails++; $display("FAIL stream_data[%0d]: got %h expected %h", got, d, e); end
            if (first_c < 0) first_c = c;
            last_c = c;
            got++;
         end
      end
      checks++;
      if (got !== 16 || last_c - first_c !== 15) begin
         fails++; $display("FAIL stream_rate: got %0d results over %0d cycles expected 16 over 16", got, last_c - first_c + 1);
      end
   endtask

   task automatic test_flush;
      logic acc, dlv;
      logic [7:0] d, e;
      int lat;
      exp_q.delete();
      for (int n = 0; n < 3; n++)
         drive_cycle(1'b1, 4'(9 + n), 2'h0, 2'd3, 1'b0, 1'b0, 1'b0, acc, dlv, d);
      drive_cycle(1'b1, 4'hC, 2'h0, 2'd3, 1'b0, 1'b1, 1'b1, acc, dlv, d);
      checks++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_cycle_ready: got %b expected 1", in_ready); end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (dlv !== 1'b1 || d !== e) begin fails++; $display("FAIL flush_delivered: got v=%b d=%h expected v=1 d=%h", dlv, d, e); end
      exp_q.delete();
      drive_cycle(1'b0, 4'h0, 2'h0, 2'd0, 1'b0, 1'b0, 1'b1, acc, dlv, d);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++; $display("FAIL flush_empty: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
      end
      drive_cycle(1'b1, 4'h3, 2'h0, 2'd3, 1'b1, 1'b0, 1'b1, acc, dlv, d);
      lat = 0; dlv = 1'b0;
      while (!dlv && lat < 10) begin
         drive_cycle(1'b0, 4'h0, 2'h0, 2'd0, 1'b0, 1'b0, 1'b1, acc, dlv, d);
         lat++;
      end
      checks++;
      if (lat !== 3 || d !== 8'hFC) begin fails++; $display("FAIL flush_after: got lat=%0d d=%h expected lat=3 d=fc", lat, d); end
      exp_q.delete();
   endtask

   task automatic test_async_reset;
      logic acc, dlv;
      logic [7:0] d;
      int lat;
      exp_q.delete();
      drive_cycle(1'b1, 4'h5, 2'h0, 2'd3, 1'b0, 1'b0, 1'b0, acc, dlv, d);
      drive_cycle(1'b1, 4'h6, 2'h0, 2'd3, 1'b0, 1'b0, 1'b0, acc, dlv, d);
      drive_cycle(1'b0, 4'h0, 2'h0, 2'd0, 1'b0, 1'b0, 1'b0, acc, dlv, d);
      drive_cycle(1'b0, 4'h0, 2'h0, 2'd0, 1'b0, 1'b0, 1'b0, acc, dlv, d);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h05) begin
         fails++; $display("FAIL pre_reset: got v=%b d=%h expected v=1 d=05", out_valid, out_data);
      end
      #2 res = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b1) begin
         fails++; $display("FAIL async_reset: got v=%b d=%h rdy=%b expected v=0 d=00 rdy=1", out_valid, out_data, in_ready);
      end
      #4 res = 1'b1;
      exp_q.delete();
      drive_cycle(1'b1, 4'h7, 2'h0, 2'd3, 1'b0, 1'b0, 1'b1, acc, dlv, d);
      checks++;
      if (acc !== 1'b1) begin fails++; $display("FAIL post_reset_accept: got %b expected 1", acc); end
      lat = 0; dlv = 1'b0;
      while (!dlv && lat < 10) begin
         drive_cycle(1'b0, 4'h0, 2'h0, 2'd0, 1'b0, 1'b0, 1'b1, acc, dlv, d);
         lat++;
      end
      checks++;
      if (lat !== 3 || d !== 8'h07) begin fails++; $display("FAIL post_reset_item: got lat=%0d d=%h expected lat=3 d=07", lat, d); end
      exp_q.delete();
   endtask

   task automatic test_param_sweep;
      logic [9:0] e_t [2] = '{10'h1B9, 10'h001};
      logic [1:0] m_t [2] = '{2'd0, 2'd1};
      int lat;
      for (int n = 0; n < 2; n++) begin
         @(negedge clk);
         in_valid2 = 1'b1; in_a2 = 6'd63; in_b2 = 3'd7; in_mode2 = m_t[n]; in_inv2 = 1'b0;
         #1;
         checks++;
         if (in_ready2 !== 1'b1) begin fails++; $display("FAIL sweep_ready[%0d]: got %b expected 1", n, in_ready2); end
         @(negedge clk);
         in_valid2 = 1'b0;
         lat = 1;
         while (!out_valid2 && lat < 10) begin
            @(negedge clk);
            lat++;
         end
         checks++;
         if (lat !== 3 || out_data2 !== e_t[n]) begin
            fails++; $display("FAIL sweep_data[%0d]: got lat=%0d d=%h expected lat=3 d=%h", n, lat, out_data2, e_t[n]);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      res = 1'b0; flush = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
      in_mode = '0; in_inv = 1'b0; out_ready = 1'b1;
      flush2 = 1'b0; in_valid2 = 1'b0; in_a2 = '0; in_b2 = '0;
      in_mode2 = '0; in_inv2 = 1'b0; out_ready2 = 1'b1;
      #2;
      test_reset();
      #20 res = 1'b1;
      test_directed();
      test_backpressure();
      test_streaming();
      test_flush();
      test_async_reset();
      test_param_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
